// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: character width, FIFO
// sizing defaults and the serial framing constants used by the receiver.
package uart_rx_fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_LOG2_DEF = 4;

    // Line levels of the start and stop bits of a UART frame.
    typedef enum logic {
        FRAME_START_BIT = 1'b0,
        FRAME_STOP_BIT  = 1'b1
    } frame_bit_e;

    // Default clocks-per-bit divisor of the receiver (50 MHz / 115200).
    localparam int BAUDS_DEF = 434;

    // Number of entries held by a FIFO of the given log2 depth.
    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/uart_rx_edge_detect.sv
// Rising-edge detector for the receiver's new-data-ready level. The history
// register resets to 1 so a level already high at reset release is not
// mistaken for a fresh byte.
module uart_rx_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);

    logic nrd_prev_q;
    logic nrd_prev_d;

    // Next history value is simply the current level; the pulse is high for
    // exactly the one cycle where the level goes from low to high.
    always_comb begin
        nrd_prev_d = i_level;
        o_rise     = i_level & ~nrd_prev_q;
    end

    // Remember the level seen on the previous edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            nrd_prev_q <= 1'b1;
        end else begin
            nrd_prev_q <= nrd_prev_d;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte queue behind the UART receiver. One write per
// rising edge of I_NrD, drained with a valid/ready handshake, and a sticky
// overrun flag for bytes dropped while the queue is full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] I_DATA,
    input  logic                  I_NrD,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic                  O_VALID,
    input  logic                  I_READY,
    output logic [DEPTH_LOG2:0]   O_COUNT,
    output logic                  O_FULL,
    output logic                  O_EMPTY,
    output logic                  O_OVERRUN,
    input  logic                  I_CLR_OVR
);

    localparam int DEPTH = fifo_depth(DEPTH_LOG2);
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;

    logic wr_req;
    logic rd_fire;
    logic wr_accept;
    logic wr_drop;
    logic full;
    logic empty;

    uart_rx_edge_detect u_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (I_NrD),
        .o_rise  (wr_req)
    );

    // Status from the occupancy count; a full queue still accepts a byte when
    // a read frees a slot on the same edge.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == FULL_COUNT);
        rd_fire   = ~empty & I_READY;
        wr_accept = wr_req & (~full | rd_fire);
        wr_drop   = wr_req & full & ~rd_fire;
    end

    // Pointer, count and overrun updates; a dropped byte sets the flag with
    // priority over a clear arriving on the same edge.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_accept, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_drop) begin
            overrun_d = 1'b1;
        end else if (I_CLR_OVR) begin
            overrun_d = 1'b0;
        end
    end

    // Control state; reset discards every stored byte and ignores the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage array is never cleared; only accepted bytes are written.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= I_DATA;
        end
    end

    assign O_DATA    = mem_q[rd_ptr_q];
    assign O_VALID   = ~empty;
    assign O_EMPTY   = empty;
    assign O_FULL    = full;
    assign O_COUNT   = count_q;
    assign O_OVERRUN = overrun_q;

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each byte the receiver presents on its O_DATA/NrD outputs and queues it in a first-word-fall-through FIFO. A valid/ready handshake drains the queue to the sniffer's command/control logic. An overrun flag latches whenever a byte arrives while the queue is full.

Parameters:
DATA_WIDTH, 8, width of one received character
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries)

Ports:
clk  input  1  system clock, same domain as the UART receiver
rst  input  1  synchronous reset, active-high
I_DATA  input  DATA_WIDTH  received byte from the UART receiver's O_DATA
I_NrD  input  1  receiver's new-data-ready level; a rising edge marks a new byte on I_DATA
O_DATA  output  DATA_WIDTH  head-of-queue byte, valid while O_VALID=1
O_VALID  output  1  queue not empty
I_READY  input  1  consumer accepts O_DATA this cycle when O_VALID=1
O_COUNT  output  DEPTH_LOG2+1  number of stored bytes, 0..2^DEPTH_LOG2
O_FULL  output  1  O_COUNT == 2^DEPTH_LOG2
O_EMPTY  output  1  O_COUNT == 0
O_OVERRUN  output  1  sticky flag: a byte was dropped because the queue was full
I_CLR_OVR  input  1  single-cycle clear of O_OVERRUN

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high: rst is sampled only on rising edges of clk.
- Reset values:
  - read/write pointers 0, count 0
  - O_VALID=0, O_EMPTY=1, O_FULL=0, O_COUNT=0, O_OVERRUN=0
  - O_DATA holds don't-care contents; memory is not cleared
  - nrd_prev=1, so an I_NrD level already high when reset releases does not produce a write
- Capture:
  - nrd_prev is a register holding I_NrD from the previous edge.
  - wr_req = I_NrD & ~nrd_prev, i.e. one write per receiver byte regardless of how long NrD stays high.
  - I_DATA is sampled on the same edge that wr_req is evaluated.
- Write:
  - On an edge with wr_req=1 and the queue not full: mem[wr_ptr] <= I_DATA, wr_ptr increments (modulo depth), count increments.
- Read:
  - rd_fire = O_VALID & I_READY.
  - On an edge with rd_fire=1: rd_ptr increments (modulo depth), count decrements.
  - I_READY while empty has no effect.
- FWFT / latency:
  - O_DATA = mem[rd_ptr], combinational from the pointer register; O_VALID = ~O_EMPTY.
  - A byte written at edge k is visible on O_DATA with O_VALID=1 immediately after edge k when the queue was empty, i.e. 1 cycle after the NrD edge is sampled.
- Simultaneous write and read:
  - Both occur; count is unchanged.
  - When full, a write coincident with rd_fire is accepted (no overrun), because the slot frees on that same edge.
  - When empty, no read fires, so only the write occurs.
- Full without read:
  - wr_req is dropped, memory and pointers are unchanged, and O_OVERRUN <= 1.
- O_OVERRUN:
  - Set has priority over I_CLR_OVR on the same edge.
  - Stays set until cleared or reset.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. Full/empty are derived from count, not from pointer comparison.
- Reset mid-operation: on the edge where rst=1, all stored bytes are discarded and any wr_req or rd_fire on that edge is ignored.

Decomposition:
- Shared package/header: DATA_WIDTH default and the UART framing constants (start/stop bit values, BAUDS divisor defaults) already used by the receiver.
- One natural sub-module: uart_rx_edge_detect (nrd_prev register plus rising-edge pulse, with reset value 1). The storage array and pointer logic stay in the top module.

Test Plan:
- Reset, then hold I_NrD low for 10 cycles -> O_EMPTY=1, O_VALID=0, O_COUNT=0, O_OVERRUN=0.
- Single byte: I_DATA=8'hFF, I_NrD rises and stays high 50 cycles, I_READY=0 -> exactly one write; O_COUNT=1, O_DATA=8'hFF, O_VALID=1 one cycle after the edge. Then I_READY=1 for one cycle -> O_COUNT=0, O_VALID=0.
- Ordering: bytes 8'h69, 8'hA5, 8'h3C via three NrD pulses, I_READY=0, then I_READY=1 -> O_DATA sequence 69, A5, 3C on three consecutive cycles, then empty.
- Fill and overrun: 16 pulses with I_READY=0 -> O_FULL=1, O_COUNT=16. A 17th pulse with I_DATA=8'h55 -> O_OVERRUN=1 and O_COUNT stays 16. Draining 16 bytes returns the first 16 values and 8'h55 never appears. Then I_CLR_OVR pulse -> O_OVERRUN=0.
- Full with simultaneous read and write: queue full, I_READY=1 on the same edge as an NrD rising edge -> O_COUNT stays 16, O_OVERRUN stays 0, and the new byte appears last after draining. Repeat 20 times to exercise pointer wrap-around.
- Reset mid-operation:
  - 5 bytes queued, then rst=1 for one cycle coincident with an NrD rising edge -> O_COUNT=0, O_OVERRUN=0, and the coincident byte is not stored.
  - I_NrD held high across the reset release -> no write until I_NrD falls and rises again.
